// File: rtl/vga_sync_gen.sv
// VGA horizontal/vertical timing generator. It advances on the pixel-clock divider's tick and
// drives registered sync, visible-area and pixel-coordinate outputs to the pixel-colour stage.
module vga_sync_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter logic        SYNC_POL  = 1'b0,
    parameter int unsigned CNT_W     = 10
) (
    input  logic             inClock,
    input  logic             reset,
    input  logic             pixTick,
    output logic [CNT_W-1:0] hCount,
    output logic [CNT_W-1:0] vCount,
    output logic             hSync,
    output logic             vSync,
    output logic             videoOn,
    output logic             lineStart,
    output logic             frameStart
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] H_LAST       = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST       = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS_END    = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS_END    = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] H_SYNC_START = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] H_SYNC_END   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_START = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] V_SYNC_END   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

    localparam logic SYNC_ON  = SYNC_POL;
    localparam logic SYNC_OFF = ~SYNC_POL;

    logic [CNT_W-1:0] h_count_q, h_count_d;
    logic [CNT_W-1:0] v_count_q, v_count_d;
    logic             h_sync_q, h_sync_d;
    logic             v_sync_q, v_sync_d;
    logic             video_on_q, video_on_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;
    logic             h_wrap, v_wrap;

    always_comb begin
        h_wrap        = (h_count_q == H_LAST);
        v_wrap        = (v_count_q == V_LAST);
        h_count_d     = h_count_q;
        v_count_d     = v_count_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;

        if (pixTick) begin
            if (h_wrap) begin
                h_count_d    = '0;
                line_start_d = 1'b1;
                if (v_wrap) begin
                    v_count_d     = '0;
                    frame_start_d = 1'b1;
                end else begin
                    v_count_d = v_count_q + CNT_W'(1);
                end
            end else begin
                h_count_d = h_count_q + CNT_W'(1);
            end
        end

        // Decode from the next counter values so the flags line up with hCount/vCount.
        h_sync_d   = ((h_count_d >= H_SYNC_START) && (h_count_d < H_SYNC_END)) ? SYNC_ON
                                                                             : SYNC_OFF;
        v_sync_d   = ((v_count_d >= V_SYNC_START) && (v_count_d < V_SYNC_END)) ? SYNC_ON
                                                                             : SYNC_OFF;
        video_on_d = (h_count_d < H_VIS_END) && (v_count_d < V_VIS_END);
    end

    // Reset parks on the last pixel of the frame so the first tick lands on (0,0).
    always_ff @(posedge inClock or posedge reset) begin
        if (reset) begin
            h_count_q     <= H_LAST;
            v_count_q     <= V_LAST;
            h_sync_q      <= SYNC_OFF;
            v_sync_q      <= SYNC_OFF;
            video_on_q    <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_count_q     <= h_count_d;
            v_count_q     <= v_count_d;
            h_sync_q      <= h_sync_d;
            v_sync_q      <= v_sync_d;
            video_on_q    <= video_on_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hCount     = h_count_q;
    assign vCount     = v_count_q;
    assign hSync      = h_sync_q;
    assign vSync      = v_sync_q;
    assign videoOn    = video_on_q;
    assign lineStart  = line_start_q;
    assign frameStart = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: default 640x480 timing on one instance, a tiny active-high-sync timing
// (12x8 totals) on a second so whole frames fit in a short run.
module tb_vga_sync_gen;

    localparam int unsigned CW = 10;

    logic inClock = 1'b0;
    logic reset   = 1'b1;
    logic pixTick = 1'b0;

    always #5 inClock = ~inClock;

    logic [CW-1:0] a_h, a_v, b_h, b_v;
    logic          a_hs, a_vs, a_vo, a_ls, a_fs;
    logic          b_hs, b_vs, b_vo, b_ls, b_fs;

    vga_sync_gen u_dut_a (
        .inClock   (inClock),
        .reset     (reset),
        .pixTick   (pixTick),
        .hCount    (a_h),
        .vCount    (a_v),
        .hSync     (a_hs),
        .vSync     (a_vs),
        .videoOn   (a_vo),
        .lineStart (a_ls),
        .frameStart(a_fs)
    );

    // 12 pixels/line (hSync 8..10), 8 lines/frame (vSync 5..6), visible 6x4.
    vga_sync_gen #(
        .H_VISIBLE(6),
        .H_FRONT  (2),
        .H_SYNC   (3),
        .H_BACK   (1),
        .V_VISIBLE(4),
        .V_FRONT  (1),
        .V_SYNC   (2),
        .V_BACK   (1),
        .SYNC_POL (1'b1),
        .CNT_W    (CW)
    ) u_dut_b (
        .inClock   (inClock),
        .reset     (reset),
        .pixTick   (pixTick),
        .hCount    (b_h),
        .vCount    (b_v),
        .hSync     (b_hs),
        .vSync     (b_vs),
        .videoOn   (b_vo),
        .lineStart (b_ls),
        .frameStart(b_fs)
    );

    int n_vec  = 0;
    int n_miss = 0;
    int ticks  = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic t);
        pixTick = t;
        @(posedge inClock);
        #1;
        if (t) ticks++;
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b1);
    endtask

    task automatic check_a_reset(input string tag);
        check_val({tag, "_a_h"}, int'(a_h), 799);
        check_val({tag, "_a_v"}, int'(a_v), 524);
        check_val({tag, "_a_hs"}, int'(a_hs), 1);
        check_val({tag, "_a_vs"}, int'(a_vs), 1);
        check_val({tag, "_a_vo"}, int'(a_vo), 0);
        check_val({tag, "_a_ls"}, int'(a_ls), 0);
        check_val({tag, "_a_fs"}, int'(a_fs), 0);
        check_val({tag, "_b_h"}, int'(b_h), 11);
        check_val({tag, "_b_v"}, int'(b_v), 7);
        check_val({tag, "_b_hs"}, int'(b_hs), 0);
        check_val({tag, "_b_vs"}, int'(b_vs), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2*CW+2:0] snap;
        int              changes;
        int              hs_low;
        int              ls_mid;
        int              idx, bh, bv;
        int              fs_at[$];

        step(1'b0);
        step(1'b0);
        check_a_reset("rst");
        reset = 1'b0;
        step(1'b0);
        step(1'b0);

        // First tick after reset lands on (0,0) with both pulses.
        step(1'b1);
        check_val("first_h", int'(a_h), 0);
        check_val("first_v", int'(a_v), 0);
        check_val("first_vo", int'(a_vo), 1);
        check_val("first_hs", int'(a_hs), 1);
        check_val("first_ls", int'(a_ls), 1);
        check_val("first_fs", int'(a_fs), 1);
        check_val("first_b_fs", int'(b_fs), 1);
        check_val("first_b_vo", int'(b_vo), 1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0);
            check_val("idle_ls", int'(a_ls), 0);
            check_val("idle_fs", int'(a_fs), 0);
            check_val("idle_h", int'(a_h), 0);
        end

        // Divider cadence: one tick every fourth cycle up to hCount 638.
        for (int i = 0; i < 638; i++) begin
            step(1'b1);
            step(1'b0);
            step(1'b0);
            step(1'b0);
        end
        check_val("h638", int'(a_h), 638);
        step(1'b1);
        check_val("vo_h639", int'(a_vo), 1);
        step(1'b1);
        check_val("vo_h640", int'(a_vo), 0);
        check_val("hs_h640", int'(a_hs), 1);
        run_ticks(15);
        check_val("h655", int'(a_h), 655);
        check_val("hs_h655", int'(a_hs), 1);

        // Hold pixTick low: nothing may move.
        snap    = {a_h, a_v, a_hs, a_vs, a_vo};
        changes = 0;
        for (int i = 0; i < 50; i++) begin
            step(1'b0);
            if ({a_h, a_v, a_hs, a_vs, a_vo} != snap) changes++;
            if (a_ls || a_fs) changes++;
        end
        check_val("hold_static", changes, 0);
        step(1'b1);
        check_val("h656", int'(a_h), 656);
        check_val("hs_h656", int'(a_hs), 0);

        hs_low = 1;
        ls_mid = 0;
        for (int i = 657; i <= 799; i++) begin
            step(1'b1);
            if (!a_hs) hs_low++;
            if (a_ls) ls_mid++;
            if (i == 751) check_val("hs_h751", int'(a_hs), 0);
            if (i == 752) check_val("hs_h752", int'(a_hs), 1);
        end
        check_val("h799", int'(a_h), 799);
        check_val("hs_low_len", hs_low, 96);
        check_val("ls_midline", ls_mid, 0);

        // Line wrap 799 -> 0; tick 801 overall.
        step(1'b1);
        check_val("wrap_h", int'(a_h), 0);
        check_val("wrap_v", int'(a_v), 1);
        check_val("wrap_ls", int'(a_ls), 1);
        check_val("wrap_fs", int'(a_fs), 0);
        check_val("wrap_vo", int'(a_vo), 1);
        check_val("t801_b_h", int'(b_h), 8);
        check_val("t801_b_v", int'(b_v), 2);
        check_val("t801_b_hs", int'(b_hs), 1);
        check_val("t801_b_vs", int'(b_vs), 0);

        run_ticks(300);
        check_val("mid_h", int'(a_h), 300);
        check_val("mid_v", int'(a_v), 1);

        // Mid-frame reset takes effect without a clock edge.
        pixTick = 1'b0;
        reset   = 1'b1;
        #1;
        check_a_reset("midrst");
        step(1'b0);
        check_val("midrst_ls", int'(a_ls), 0);
        check_val("midrst_fs", int'(a_fs), 0);
        reset = 1'b0;
        ticks = 0;
        step(1'b0);

        // Continuous pixTick: two full small frames plus one tick, checked against a model.
        for (int t = 1; t <= 193; t++) begin
            step(1'b1);
            if (t == 1) begin
                check_val("rst_next_a_h", int'(a_h), 0);
                check_val("rst_next_a_fs", int'(a_fs), 1);
            end
            idx = t - 1;
            bh  = idx % 12;
            bv  = (idx / 12) % 8;
            check_val("b_h", int'(b_h), bh);
            check_val("b_v", int'(b_v), bv);
            check_val("b_hs", int'(b_hs), (bh >= 8 && bh <= 10) ? 1 : 0);
            check_val("b_vs", int'(b_vs), (bv >= 5 && bv <= 6) ? 1 : 0);
            check_val("b_vo", int'(b_vo), (bh < 6 && bv < 4) ? 1 : 0);
            check_val("b_ls", int'(b_ls), (bh == 0) ? 1 : 0);
            check_val("b_fs", int'(b_fs), (bh == 0 && bv == 0) ? 1 : 0);
            if (b_fs) fs_at.push_back(t);
        end
        check_val("b_fs_count", fs_at.size(), 3);
        check_val("b_frame_period", (fs_at.size() >= 2) ? fs_at[1] - fs_at[0] : -1, 96);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
